// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
//
// VGA sink for the framebuffer output path. Watches the pixel bus produced by
// the VGA output block (same clk50 domain, so no synchronisers), recovers the
// pixel coordinates, emits one write strobe per active pixel and checks that
// every line has WIDTH pixels and every frame has HEIGHT lines.
//
// Optional feature macro: VGA_CAPTURE_CRC_EN
//   When defined, a CRC-16-CCITT (poly 0x1021, init 0xFFFF) is run over the
//   {r, g, b} of every written pixel, MSB first, and published per frame on
//   frame_crc / crc_valid together with frame_done.
//
// Parameters
//   WIDTH        active pixels per line
//   HEIGHT       active lines per frame
//
// Ports
//   clk50        system clock
//   reset        synchronous, active-high reset
//   vga_r/g/b    pixel colour from the VGA output block
//   vga_clk      pixel clock, high every other clk50 cycle
//   vga_hs       horizontal sync (not needed for decoding, blank_n is used)
//   vga_vs       vertical sync, active low
//   vga_blank_n  active-video qualifier
//   wr_en        one-cycle write strobe for a captured pixel
//   wr_x, wr_y   coordinates of the captured pixel (held between writes)
//   wr_r/g/b     colour of the captured pixel (held between writes)
//   frame_start  one-cycle pulse on each accepted VS falling edge
//   frame_done   one-cycle pulse after line HEIGHT-1 completes
//   line_err     one-cycle pulse on a line with a wrong pixel count
//   frame_err    one-cycle pulse on a frame with a wrong line count
//   locked       high while the incoming geometry has been verified
//   frame_crc    (CRC build only) CRC of the frame just completed
//   crc_valid    (CRC build only) pulses with frame_done
// -----------------------------------------------------------------------------
module vga_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                      clk50,
  input  logic                      reset,
  input  logic [7:0]                vga_r,
  input  logic [7:0]                vga_g,
  input  logic [7:0]                vga_b,
  input  logic                      vga_clk,
  input  logic                      vga_hs,
  input  logic                      vga_vs,
  input  logic                      vga_blank_n,
  output logic                      wr_en,
  output logic [$clog2(WIDTH)-1:0]  wr_x,
  output logic [$clog2(HEIGHT)-1:0] wr_y,
  output logic [7:0]                wr_r,
  output logic [7:0]                wr_g,
  output logic [7:0]                wr_b,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic                      line_err,
  output logic                      frame_err,
  output logic                      locked
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0]               frame_crc,
  output logic                      crc_valid
`endif
);

  // The counters carry one extra bit so that x can reach WIDTH (overrun
  // detection) and y can reach HEIGHT (end of frame) without wrapping.
  localparam int XB = $clog2(WIDTH);
  localparam int XW = XB + 1;
  localparam int YB = $clog2(HEIGHT);
  localparam int YW = YB + 1;
  localparam logic [XW-1:0] X_END = XW'(WIDTH);
  localparam logic [YW-1:0] Y_END = YW'(HEIGHT);

  typedef enum logic [1:0] {
    SEEK,
    VBLANK,
    ACTIVE,
    HBLANK
  } state_t;

  state_t          state, state_n;
  logic            vga_clk_q;
  logic            vga_vs_q;
  logic            pix_tick;
  logic            vs_fall;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic [YW-1:0]   y_inc;
  logic            overrun, overrun_n;
  logic            done_seen, done_seen_n;
  logic            extra_seen, extra_seen_n;
  logic            frame_bad, frame_bad_n;
  logic            line_bad;

  logic            wr_en_n;
  logic [XB-1:0]   wr_x_n;
  logic [YB-1:0]   wr_y_n;
  logic [7:0]      wr_r_n, wr_g_n, wr_b_n;
  logic            frame_start_n, frame_done_n, line_err_n, frame_err_n, locked_n;

  // Horizontal sync carries no information that blank_n does not already give.
  logic unused_hs;
  assign unused_hs = vga_hs;

  // Rising edge of the pixel clock marks the cycle in which pixel data is
  // valid; the VS falling edge is watched on every system clock.
  assign pix_tick = vga_clk & ~vga_clk_q;
  assign vs_fall  = ~vga_vs & vga_vs_q;
  assign y_inc    = y + YW'(1);

  // State and output registers.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= SEEK;
      vga_clk_q   <= 1'b0;
      vga_vs_q    <= 1'b1;
      x           <= '0;
      y           <= '0;
      overrun     <= 1'b0;
      done_seen   <= 1'b0;
      extra_seen  <= 1'b0;
      frame_bad   <= 1'b0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_r        <= '0;
      wr_g        <= '0;
      wr_b        <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_n;
      vga_clk_q   <= vga_clk;
      vga_vs_q    <= vga_vs;
      x           <= x_n;
      y           <= y_n;
      overrun     <= overrun_n;
      done_seen   <= done_seen_n;
      extra_seen  <= extra_seen_n;
      frame_bad   <= frame_bad_n;
      wr_en       <= wr_en_n;
      wr_x        <= wr_x_n;
      wr_y        <= wr_y_n;
      wr_r        <= wr_r_n;
      wr_g        <= wr_g_n;
      wr_b        <= wr_b_n;
      frame_start <= frame_start_n;
      frame_done  <= frame_done_n;
      line_err    <= line_err_n;
      frame_err   <= frame_err_n;
      locked      <= locked_n;
    end
  end

  // Next-state and next-output logic. A VS falling edge always wins over a
  // coincident pixel tick and restarts frame tracking from line 0.
  always_comb begin
    state_n       = state;
    x_n           = x;
    y_n           = y;
    overrun_n     = overrun;
    done_seen_n   = done_seen;
    extra_seen_n  = extra_seen;
    frame_bad_n   = frame_bad;
    line_bad      = 1'b0;
    wr_en_n       = 1'b0;
    wr_x_n        = wr_x;
    wr_y_n        = wr_y;
    wr_r_n        = wr_r;
    wr_g_n        = wr_g;
    wr_b_n        = wr_b;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    line_err_n    = 1'b0;
    frame_err_n   = 1'b0;
    // Any error pulse drops lock on the following cycle.
    locked_n      = (line_err | frame_err) ? 1'b0 : locked;

    if (vs_fall) begin
      // A new frame starting before the previous one reached frame_done
      // means the previous frame was short.
      if ((state != SEEK) && !done_seen) begin
        frame_err_n = 1'b1;
      end
      state_n       = VBLANK;
      x_n           = '0;
      y_n           = '0;
      overrun_n     = 1'b0;
      done_seen_n   = 1'b0;
      extra_seen_n  = 1'b0;
      frame_bad_n   = 1'b0;
      frame_start_n = 1'b1;
    end else if (pix_tick) begin
      unique case (state)
        SEEK: begin
        end

        VBLANK, HBLANK: begin
          if (vga_blank_n) begin
            if ((state == VBLANK) && done_seen) begin
              // Active video after the last line: report once per frame
              // and keep the extra lines out of memory.
              if (!extra_seen) begin
                frame_err_n  = 1'b1;
                extra_seen_n = 1'b1;
              end
            end else begin
              state_n = ACTIVE;
              wr_en_n = 1'b1;
              wr_x_n  = x[XB-1:0];
              wr_y_n  = y[YB-1:0];
              wr_r_n  = vga_r;
              wr_g_n  = vga_g;
              wr_b_n  = vga_b;
              x_n     = XW'(1);
            end
          end
        end

        ACTIVE: begin
          if (vga_blank_n) begin
            if (x < X_END) begin
              wr_en_n = 1'b1;
              wr_x_n  = x[XB-1:0];
              wr_y_n  = y[YB-1:0];
              wr_r_n  = vga_r;
              wr_g_n  = vga_g;
              wr_b_n  = vga_b;
              x_n     = x + XW'(1);
            end else begin
              // Too many pixels: x stays at WIDTH and the line is marked bad.
              overrun_n = 1'b1;
            end
          end else begin
            line_bad    = (x != X_END) || overrun;
            line_err_n  = line_bad;
            frame_bad_n = frame_bad | line_bad;
            x_n         = '0;
            overrun_n   = 1'b0;
            y_n         = y_inc;
            if (y_inc == Y_END) begin
              state_n      = VBLANK;
              frame_done_n = 1'b1;
              done_seen_n  = 1'b1;
              // Lock only on a frame whose every line was clean, including
              // the one ending right now.
              if (!(frame_bad | line_bad)) begin
                locked_n = 1'b1;
              end
            end else begin
              state_n = HBLANK;
            end
          end
        end

        default: begin
          state_n = SEEK;
        end
      endcase
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT over 24 bits of pixel colour, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                           input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [15:0] crc_run, crc_run_n;
  logic [15:0] frame_crc_n;
  logic        crc_valid_n;

  // The running CRC folds in each write the cycle it is presented on wr_en.
  // The snapshot taken for frame_done uses the next value so that a write
  // still in flight is never lost.
  always_comb begin
    crc_run_n   = crc_run;
    frame_crc_n = frame_crc;
    crc_valid_n = 1'b0;
    if (wr_en) begin
      crc_run_n = crc_step(crc_run, {wr_r, wr_g, wr_b});
    end
    if (frame_done_n) begin
      frame_crc_n = crc_run_n;
      crc_valid_n = 1'b1;
    end
    if (frame_start_n) begin
      crc_run_n = 16'hFFFF;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_run   <= crc_run_n;
      frame_crc <= frame_crc_n;
      crc_valid <= crc_valid_n;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_capture
//
// Drives vga_capture with a scaled-down geometry (10x6) pixel stream and
// compares writes and status pulses against a frame-level model: a frame is
// described by its number of lines and the active length of each line, and
// the expected writes, error pulses and lock state follow from those numbers.
// -----------------------------------------------------------------------------
module tb_vga_capture;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int XB = $clog2(W);
  localparam int YB = $clog2(H);

  logic           clk50 = 1'b0;
  logic           reset;
  logic [7:0]     vga_r, vga_g, vga_b;
  logic           vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic           wr_en;
  logic [XB-1:0]  wr_x;
  logic [YB-1:0]  wr_y;
  logic [7:0]     wr_r, wr_g, wr_b;
  logic           frame_start, frame_done, line_err, frame_err, locked;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0]    frame_crc;
  logic           crc_valid;
  logic [15:0]    crc_last = '0;
`endif

  vga_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_clk     (vga_clk),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_r        (wr_r),
    .wr_g        (wr_g),
    .wr_b        (wr_b),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .locked      (locked)
`ifdef VGA_CAPTURE_CRC_EN
    ,
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
`endif
  );

  always #10 clk50 = ~clk50;

  typedef struct packed {
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
  } wr_t;

  typedef struct {
    int nlines;
    int bad_line;
    int bad_len;
    int exp_writes;
    int exp_lerr;
    int exp_ferr;
    int exp_done;
    bit exp_locked;
  } frame_vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  line_len[16];
  int  checks = 0;
  int  errors = 0;

  // Event counters filled by the monitor.
  int   n_start = 0, n_done = 0, n_lerr = 0, n_ferr = 0, n_wide = 0;
  logic wr_en_prev = 1'b0;

  // Frame-level model state.
  bit m_started = 0;
  bit m_done_prev = 0;
  bit m_locked = 0;

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk50) begin
    if (wr_en) begin
      obs_q.push_back('{x: wr_x, y: wr_y, r: wr_r, g: wr_g, b: wr_b});
      if (wr_en_prev) n_wide <= n_wide + 1;
    end
    wr_en_prev <= wr_en;
    if (frame_start) n_start <= n_start + 1;
    if (frame_done)  n_done  <= n_done + 1;
    if (line_err)    n_lerr  <= n_lerr + 1;
    if (frame_err)   n_ferr  <= n_ferr + 1;
`ifdef VGA_CAPTURE_CRC_EN
    if (crc_valid)   crc_last <= frame_crc;
`endif
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One pixel period: vga_clk high for one clk50 cycle, then low for one.
  task automatic applyStimulus(input logic blank_n, input logic hs, input logic vs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk50);
    vga_clk     = 1'b1;
    vga_blank_n = blank_n;
    vga_hs      = hs;
    vga_vs      = vs;
    vga_r       = r;
    vga_g       = g;
    vga_b       = b;
    @(negedge clk50);
    vga_clk     = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk50);
    #2;
  endtask

  task automatic send_vs();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  // Mode 0: r = column, g = line, b = 0x5A. Mode 1: random colour.
  // Mode 2: as mode 0 with one pixel of line 2 altered.
  task automatic send_line(input int l, input int p0, input int p1, input int mode, input bit hbl);
    logic [7:0] r, g, b;
    for (int p = p0; p < p1; p++) begin
      r = 8'(p);
      g = 8'(l);
      b = 8'h5A;
      if (mode == 1) begin
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
      end
      if (mode == 2 && l == 2 && p == 3) r = r ^ 8'h01;
      applyStimulus(1'b1, 1'b1, 1'b1, r, g, b);
      if (l < H && p < W) exp_q.push_back('{x: XB'(p), y: YB'(l), r: r, g: g, b: b});
    end
    if (hbl) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic send_porch();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic set_lens(input int bad_line, input int bad_len);
    foreach (line_len[i]) line_len[i] = (i == bad_line) ? bad_len : W;
  endtask

  // Frame-level reference: writes are the first W pixels of each of the
  // first H lines; a line is bad if its length is not W; a frame is short if
  // it has fewer than H lines and long if it has more.
  task automatic model_predict(input int nlines, output int ew, output int ele,
                               output int efe, output int efd, output bit elk);
    int eff;
    bit extra, start_err;
    eff = (nlines < H) ? nlines : H;
    ew  = 0;
    ele = 0;
    for (int l = 0; l < eff; l++) begin
      ew  += (line_len[l] < W) ? line_len[l] : W;
      ele += (line_len[l] != W) ? 1 : 0;
    end
    efd       = (nlines >= H) ? 1 : 0;
    extra     = (nlines > H);
    start_err = m_started && !m_done_prev;
    efe       = int'(start_err) + int'(extra);
    if (extra)                       elk = 1'b0;
    else if (efd == 1)               elk = (ele == 0);
    else if (ele > 0 || start_err)   elk = 1'b0;
    else                             elk = m_locked;
    m_started   = 1'b1;
    m_done_prev = (efd == 1);
    m_locked    = elk;
  endtask

  task automatic run_frame(input string tag, input int nlines, input int mode,
                           input int ew, input int ele, input int efe, input int efd, input bit elk);
    int s0, d0, l0, f0, w0, first_bad, n;
    settle();
    s0 = n_start; d0 = n_done; l0 = n_lerr; f0 = n_ferr; w0 = n_wide;
    obs_q.delete();
    exp_q.delete();
    send_vs();
    for (int l = 0; l < nlines; l++) send_line(l, 0, line_len[l], mode, 1'b1);
    send_porch();
    settle();
    first_bad = -1;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] != exp_q[i]) begin
        first_bad = i;
        break;
      end
    end
    checkOutput({tag, "/writes"},      obs_q.size(), ew);
    checkOutput({tag, "/write_data"},  first_bad, -1);
    checkOutput({tag, "/frame_start"}, n_start - s0, 1);
    checkOutput({tag, "/line_err"},    n_lerr - l0, ele);
    checkOutput({tag, "/frame_err"},   n_ferr - f0, efe);
    checkOutput({tag, "/frame_done"},  n_done - d0, efd);
    checkOutput({tag, "/locked"},      int'(locked), int'(elk));
    checkOutput({tag, "/wr_en_width"}, n_wide - w0, 0);
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic [23:0] d;
    c = 16'hFFFF;
    foreach (exp_q[k]) begin
      d = {exp_q[k].r, exp_q[k].g, exp_q[k].b};
      for (int i = 23; i >= 0; i--) begin
        c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_vec_t vecs[11];
    int  ew, ele, efe, efd, s0, d0, l0, f0, r;
    bit  elk;
    string tag;

    vecs[0]  = '{6, -1, 0,  60, 0, 0, 1, 1'b1};
    vecs[1]  = '{6,  2, 9,  59, 1, 0, 1, 1'b0};
    vecs[2]  = '{6, -1, 0,  60, 0, 0, 1, 1'b1};
    vecs[3]  = '{6,  4, 11, 60, 1, 0, 1, 1'b0};
    vecs[4]  = '{6, -1, 0,  60, 0, 0, 1, 1'b1};
    vecs[5]  = '{3, -1, 0,  30, 0, 0, 0, 1'b1};
    vecs[6]  = '{6, -1, 0,  60, 0, 1, 1, 1'b1};
    vecs[7]  = '{7, -1, 0,  60, 0, 1, 1, 1'b0};
    vecs[8]  = '{6, -1, 0,  60, 0, 0, 1, 1'b1};
    vecs[9]  = '{4,  1, 9,  39, 1, 0, 0, 1'b0};
    vecs[10] = '{6, -1, 0,  60, 0, 1, 1, 1'b1};

    reset = 1'b1;
    vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    repeat (3) @(negedge clk50);
    settle();
    checkOutput("reset/wr_en",       int'(wr_en), 0);
    checkOutput("reset/wr_x",        int'(wr_x), 0);
    checkOutput("reset/wr_y",        int'(wr_y), 0);
    checkOutput("reset/wr_r",        int'(wr_r), 0);
    checkOutput("reset/wr_g",        int'(wr_g), 0);
    checkOutput("reset/wr_b",        int'(wr_b), 0);
    checkOutput("reset/frame_start", int'(frame_start), 0);
    checkOutput("reset/frame_done",  int'(frame_done), 0);
    checkOutput("reset/line_err",    int'(line_err), 0);
    checkOutput("reset/frame_err",   int'(frame_err), 0);
    checkOutput("reset/locked",      int'(locked), 0);
    @(negedge clk50);
    reset = 1'b0;

    // Directed frames with hand-derived expectations.
    for (int i = 0; i < 11; i++) begin
      set_lens(vecs[i].bad_line, vecs[i].bad_len);
      model_predict(vecs[i].nlines, ew, ele, efe, efd, elk);
      tag = $sformatf("vec%0d", i);
      run_frame(tag, vecs[i].nlines, 0, vecs[i].exp_writes, vecs[i].exp_lerr,
                vecs[i].exp_ferr, vecs[i].exp_done, vecs[i].exp_locked);
    end

    // Randomised frames checked against the frame-level model.
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 9));
      foreach (line_len[k]) begin
        line_len[k] = W;
        if ($urandom_range(0, 5) == 0) line_len[k] = int'($urandom_range(W - 2, W + 2));
      end
      model_predict((r < 6) ? H : (r == 6) ? H - 2 : (r == 7) ? H - 1 : (r == 8) ? H + 1 : H + 2,
                    ew, ele, efe, efd, elk);
      tag = $sformatf("rnd%0d", i);
      run_frame(tag, (r < 6) ? H : (r == 6) ? H - 2 : (r == 7) ? H - 1 : (r == 8) ? H + 1 : H + 2,
                1, ew, ele, efe, efd, elk);
    end

    // Reset in the middle of line 2, then let the rest of the frame run.
    set_lens(-1, 0);
    settle();
    obs_q.delete();
    send_vs();
    send_line(0, 0, W, 0, 1'b1);
    send_line(1, 0, W, 0, 1'b1);
    send_line(2, 0, 4, 0, 1'b0);
    settle();
    checkOutput("midreset/pre_writes", obs_q.size(), 2 * W + 4);
    @(negedge clk50);
    reset = 1'b1;
    settle();
    checkOutput("midreset/wr_en_in_reset", int'(wr_en), 0);
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    settle();
    s0 = n_start; d0 = n_done; l0 = n_lerr; f0 = n_ferr;
    obs_q.delete();
    send_line(2, 4, W, 0, 1'b1);
    for (int l = 3; l < H; l++) send_line(l, 0, W, 0, 1'b1);
    send_porch();
    settle();
    checkOutput("midreset/writes",      obs_q.size(), 0);
    checkOutput("midreset/frame_start", n_start - s0, 0);
    checkOutput("midreset/frame_done",  n_done - d0, 0);
    checkOutput("midreset/line_err",    n_lerr - l0, 0);
    checkOutput("midreset/frame_err",   n_ferr - f0, 0);
    checkOutput("midreset/locked",      int'(locked), 0);
    m_started = 1'b0; m_done_prev = 1'b0; m_locked = 1'b0;
    model_predict(H, ew, ele, efe, efd, elk);
    run_frame("after_reset", H, 0, ew, ele, efe, efd, elk);

`ifdef VGA_CAPTURE_CRC_EN
    begin
      logic [15:0] c1, c2, c3;
      set_lens(-1, 0);
      model_predict(H, ew, ele, efe, efd, elk);
      run_frame("crc1", H, 0, ew, ele, efe, efd, elk);
      c1 = crc_last;
      checkOutput("crc1/model", int'(c1), int'(model_crc()));
      model_predict(H, ew, ele, efe, efd, elk);
      run_frame("crc2", H, 0, ew, ele, efe, efd, elk);
      c2 = crc_last;
      checkOutput("crc2/repeat", int'(c2), int'(c1));
      model_predict(H, ew, ele, efe, efd, elk);
      run_frame("crc3", H, 2, ew, ele, efe, efd, elk);
      c3 = crc_last;
      checkOutput("crc3/model", int'(c3), int'(model_crc()));
      checkOutput("crc3/changed", int'(c3 != c1), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
